rs_seg_pipe_adder: RTL and testbench
====================================

Name: rs_seg_pipe_adder

Overview:
- Pipelined wide adder/subtractor for genesis3.
- Splits operands wider than one carry chain into SEG_WIDTH slices and registers the carry between slices, so no combinational chain exceeds SEG_WIDTH.
- Each slice add is written as a plain `+` so techmap lowers it to one adder_carry chain.
- Sits upstream of the arith mapping, in the DSP/accumulator datapath; consumers get a registered, deskewed result with valid/ready handshake.

Parameters:
- WIDTH, 128, operand and result width in bits (≥2).
- SEG_WIDTH, 64, slice width; must be ≤ MAX_CARRY_CHAIN and ≥3 so the arith map accepts it.
- NSEG, derived = ceil(WIDTH/SEG_WIDTH), number of pipeline stages; last slice may be narrower.

Ports:
- C, input, 1, clock, rising edge.
- R, input, 1, asynchronous active-low reset.
- in_valid, input, 1, operand beat valid.
- in_ready, output, 1, block can accept a beat.
- a, input, WIDTH, operand A (unsigned bit vector).
- b, input, WIDTH, operand B.
- ci, input, 1, carry-in.
- bi, input, 1, 1 = invert B (a - b with ci=1).
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- sum, output, WIDTH, result bits.
- co, output, 1, carry-out of MSB.

Behaviour:
- Reset (R low, async): all stage valid bits 0, out_valid=0, sum=0, co=0; in_ready comes up 1 once R is released.
- Global advance: adv = ~out_valid | out_ready. All stage registers, including skew and deskew regs, load only when adv=1. in_ready = adv.
- Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
- Stage k (0..NSEG-1) computes {c_k, s_k} = A_k + (bi_k ? ~B_k : B_k) + c_{k-1}, with c_{-1} = ci.
  - Registers s_k, c_k, and passes the remaining upper operand slices and bi forward.
- Operand skew: slice k of a/b/bi is delayed k cycles so it meets its carry.
- Result deskew: s_k is delayed NSEG-1-k cycles.
- Latency: exactly NSEG cycles from input transfer to out_valid with adv held 1.
- Throughput: one beat per cycle.
- Bubbles: invalid beats propagate as valid=0. Datapath regs of a bubble may hold don't-care values; sum and co are only meaningful when out_valid=1.
- Stall: out_valid=1 & out_ready=0 freezes the whole pipe. sum and co hold stable; no beat lost or duplicated.
- Simultaneous in/out transfer on a full pipe is legal and sustains full rate.
- Wrap-around: results are modulo 2^WIDTH; co = bit WIDTH of the full sum, no saturation.
- Last slice width is WIDTH - (NSEG-1)*SEG_WIDTH.
- NSEG=1: single registered stage with latency 1.
- Reset mid-operation: all in-flight beats are discarded and valids cleared in the same cycle, asynchronously.

Optional Feature:
- Macro RS_SEG_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), meaning signed two's-complement overflow = c_{MSB-1} ^ co, computed in the last stage.
  - Registered and deskewed with sum; reset 0; held stable on stall.
- Undefined: port absent; no extra logic.

Decomposition:
- Package rs_seg_pipe_adder_pkg holds:
  - function nseg(width, seg);
  - function seg_lo(k, seg) and seg_w(k, width, seg) for slice bounds;
  - localparam MAX_CARRY_CHAIN default, shared with the arith map.
- Sub-module rs_seg_add_stage: one slice adder with registered {carry, sum}, enable and async reset, parameterised by slice width. Instantiated NSEG times in a generate loop.
- Skew/deskew shift registers are generated inline in the top module.

Test Plan:
- WIDTH=128, SEG=64, out_ready=1: a=0x0000..FFFF_FFFF_FFFF_FFFF, b=1, ci=0, bi=0 → after 2 cycles sum=0x0000_0000_0000_0001_0000_0000_0000_0000, co=0 (carry crosses the slice boundary).
- a=all-ones, b=0, ci=1 → sum=0, co=1. With RS_SEG_ADD_OVF_EN: ovf=0. Then a=0x7FFF..F, b=1 → ovf=1.
- Subtract: a=5, b=7, bi=1, ci=1 → sum=2^128-2 (0xFF..FE), co=0. Then a=7, b=5 → sum=2, co=1.
- Back-to-back 100 random beats with out_ready toggling pseudo-randomly → scoreboard matches a+b'+ci in order, no drops or duplicates; sum stable while stalled.
- R asserted with 2 beats in flight → out_valid=0 and sum=0 immediately. After release, a new beat a=3, b=4 → sum=7 after exactly 2 cycles.
- WIDTH=100, SEG=64 (last slice 36 bits) and WIDTH=48, SEG=64 (NSEG=1, latency 1) → random beats match the reference model.

Source files
------------

// File: rtl/rs_seg_pipe_adder_pkg.sv
// rs_seg_pipe_adder_pkg
//   Shared constants and slice-geometry helpers for the segmented pipelined
//   adder. MAX_CARRY_CHAIN is also used by the arith map. It is the longest
//   adder_carry chain that the map will build without splitting it.
//   No ports (package).
package rs_seg_pipe_adder_pkg;

  localparam int MAX_CARRY_CHAIN = 64;

  // Number of slices (= pipeline stages) needed to cover 'width' bits.
  function automatic int nseg(input int width, input int seg);
    return (width + seg - 1) / seg;
  endfunction

  // LSB position of slice k.
  function automatic int seg_lo(input int k, input int seg);
    return k * seg;
  endfunction

  // Width of slice k. Only the last slice can be narrower than 'seg'.
  function automatic int seg_w(input int k, input int width, input int seg);
    int rem;
    rem = width - k * seg;
    return (rem < seg) ? rem : seg;
  endfunction

endpackage

// File: rtl/rs_seg_add_stage.sv
// rs_seg_add_stage
//   One slice of the segmented adder. It computes {co, sum} = a + (bi ? ~b : b) + ci
//   as a single '+' expression, so techmap lowers it to one carry chain.
//   The result is registered with an enable.
//   Optional feature macro: RS_SEG_ADD_OVF_EN adds o_ovf. This is the registered
//   signed overflow (carry into the MSB xor carry out of the MSB). Only the top
//   slice uses it.
// Ports:
//   gclk    in   clock, rising edge
//   grst_n  in   async active-low reset, clears sum/co(/ovf)
//   i_en    in   load enable (pipeline advance)
//   i_a     in   [SW] slice of operand A
//   i_b     in   [SW] slice of operand B
//   i_bi    in   invert B
//   i_ci    in   carry into this slice
//   o_sum   out  [SW] registered slice sum
//   o_co    out  registered carry out of this slice
//   o_ovf   out  registered signed overflow (macro only)
module rs_seg_add_stage
  import rs_seg_pipe_adder_pkg::*;
#(
  parameter int SW = 64
) (
  input  logic          gclk,
  input  logic          grst_n,
  input  logic          i_en,
  input  logic [SW-1:0] i_a,
  input  logic [SW-1:0] i_b,
  input  logic          i_bi,
  input  logic          i_ci,
  output logic [SW-1:0] o_sum,
  output logic          o_co
`ifdef RS_SEG_ADD_OVF_EN
  ,
  output logic          o_ovf
`endif
);

  logic [SW-1:0] w_bx;
  logic [SW:0]   w_full;
  logic [SW-1:0] r_sum;
  logic          r_co;

  assign w_bx   = i_bi ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_bx} + {{SW{1'b0}}, i_ci};

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      r_sum <= '0;
      r_co  <= 1'b0;
    end else if (i_en) begin
      r_sum <= w_full[SW-1:0];
      r_co  <= w_full[SW];
    end
  end

  assign o_sum = r_sum;
  assign o_co  = r_co;

`ifdef RS_SEG_ADD_OVF_EN
  // Carry into the MSB is recovered from the MSB sum bit, so no second chain
  // is needed: s = a ^ b ^ c_in  =>  c_in = a ^ b ^ s.
  logic w_c_msb_in;
  logic r_ovf;

  assign w_c_msb_in = i_a[SW-1] ^ w_bx[SW-1] ^ w_full[SW-1];

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)   r_ovf <= 1'b0;
    else if (i_en) r_ovf <= w_c_msb_in ^ w_full[SW];
  end

  assign o_ovf = r_ovf;
`endif

endmodule

// File: rtl/rs_seg_pipe_adder.sv
// rs_seg_pipe_adder
//   Pipelined wide adder/subtractor. The operands are cut into SEG_WIDTH
//   slices. Slice k adds in stage k, using the registered carry from slice k-1,
//   so no combinational carry chain is longer than SEG_WIDTH. Operand slices
//   are skewed on the way in and result slices are deskewed on the way out.
//   The consumer therefore sees one aligned result NSEG cycles after the
//   input transfer.
//   The whole pipe advances together (adv = ~out_valid | out_ready). A stalled
//   output freezes every register, including the skew and deskew registers.
//   Optional feature macro: RS_SEG_ADD_OVF_EN adds port ovf. This is the signed
//   two's-complement overflow of the full-width add.
// Ports:
//   C          in   clock, rising edge
//   R          in   async active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  beat accepted this cycle when in_valid is high
//   a, b       in   [WIDTH] operands (unsigned bit vectors)
//   ci         in   carry-in
//   bi         in   invert b (a - b with ci = 1)
//   out_valid  out  result valid
//   out_ready  in   consumer takes the result
//   sum        out  [WIDTH] result, modulo 2^WIDTH
//   co         out  carry out of the MSB
//   ovf        out  signed overflow (macro only)
module rs_seg_pipe_adder
  import rs_seg_pipe_adder_pkg::*;
#(
  parameter int WIDTH     = 128,
  parameter int SEG_WIDTH = 64
) (
  input  logic             C,
  input  logic             R,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co
`ifdef RS_SEG_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = nseg(WIDTH, SEG_WIDTH);

  logic            w_adv;
  logic [NSEG:1]   r_vld_pipe;  // r_vld_pipe[k]: stage k-1 holds a real beat
  logic [NSEG-1:0] w_co;        // registered carry out of each stage
`ifdef RS_SEG_ADD_OVF_EN
  logic [NSEG-1:0] w_ovf;
`endif

  assign w_adv     = ~r_vld_pipe[NSEG] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld_pipe[NSEG];

  // Stage 1 loads in_valid when adv is high. This is the same as the input
  // transfer because in_ready == adv. Bubbles travel as 0.
  always_ff @(posedge C or negedge R) begin
    if (!R) begin
      r_vld_pipe <= '0;
    end else if (w_adv) begin
      r_vld_pipe[1] <= in_valid;
      for (int k = 2; k <= NSEG; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    localparam int LO  = seg_lo(k, SEG_WIDTH);
    localparam int SW  = seg_w(k, WIDTH, SEG_WIDTH);
    localparam int DSK = NSEG - 1 - k;

    logic [SW-1:0] w_a;
    logic [SW-1:0] w_b;
    logic [SW-1:0] w_s;
    logic          w_bi;
    logic          w_ci;

    if (k == 0) begin : g_head
      assign w_a  = a[LO +: SW];
      assign w_b  = b[LO +: SW];
      assign w_bi = bi;
      assign w_ci = ci;
    end else begin : g_skew
      // Slice k waits k cycles so that it meets the carry from slice k-1.
      // bi travels with each slice because each stage needs it.
      logic [2*SW:0] r_sk [k];

      always_ff @(posedge C or negedge R) begin
        if (!R) begin
          for (int j = 0; j < k; j++) r_sk[j] <= '0;
        end else if (w_adv) begin
          r_sk[0] <= {bi, b[LO +: SW], a[LO +: SW]};
          for (int j = 1; j < k; j++) r_sk[j] <= r_sk[j-1];
        end
      end

      assign {w_bi, w_b, w_a} = r_sk[k-1];
      assign w_ci             = w_co[k-1];
    end

    rs_seg_add_stage #(.SW(SW)) u_stage (
      .gclk   (C),
      .grst_n (R),
      .i_en   (w_adv),
      .i_a    (w_a),
      .i_b    (w_b),
      .i_bi   (w_bi),
      .i_ci   (w_ci),
      .o_sum  (w_s),
      .o_co   (w_co[k])
`ifdef RS_SEG_ADD_OVF_EN
      ,
      .o_ovf  (w_ovf[k])
`endif
    );

    if (DSK == 0) begin : g_nodsk
      assign sum[LO +: SW] = w_s;
    end else begin : g_dsk
      // Lower slices finish early. Hold each one until the top slice catches up.
      logic [SW-1:0] r_dsk [DSK];

      always_ff @(posedge C or negedge R) begin
        if (!R) begin
          for (int j = 0; j < DSK; j++) r_dsk[j] <= '0;
        end else if (w_adv) begin
          r_dsk[0] <= w_s;
          for (int j = 1; j < DSK; j++) r_dsk[j] <= r_dsk[j-1];
        end
      end

      assign sum[LO +: SW] = r_dsk[DSK-1];
    end
  end

  assign co = w_co[NSEG-1];

`ifdef RS_SEG_ADD_OVF_EN
  assign ovf = w_ovf[NSEG-1];
`endif

endmodule

// File: tb/tb_rs_seg_pipe_adder.sv
// tb_rs_seg_pipe_adder
//   Three instances: 128/64 (two stages), 100/64 (36-bit top slice) and
//   48/64 (single stage). Directed table vectors and a mid-flight reset run on
//   the 128-bit instance. Every instance gets latency checks and random
//   streams with a throttled consumer, checked against an arithmetic
//   reference model.
module tb_rs_seg_pipe_adder;

  logic C = 1'b0;
  always #5 C = ~C;

  logic [2:0]   R_x, in_v, o_rdy, ci_x, bi_x;
  logic [2:0]   in_rdy_x, out_v_x, co_x;
  logic [127:0] a_x [3];
  logic [127:0] b_x [3];
  logic [127:0] sum_x [3];
  logic [127:0] s0;
  logic [99:0]  s1;
  logic [47:0]  s2;
`ifdef RS_SEG_ADD_OVF_EN
  logic [2:0]   ovf_x;
`endif

  assign sum_x[0] = s0;
  assign sum_x[1] = {28'b0, s1};
  assign sum_x[2] = {80'b0, s2};

  rs_seg_pipe_adder #(.WIDTH(128), .SEG_WIDTH(64)) u_dut0 (
    .C(C), .R(R_x[0]), .in_valid(in_v[0]), .in_ready(in_rdy_x[0]),
    .a(a_x[0]), .b(b_x[0]), .ci(ci_x[0]), .bi(bi_x[0]),
    .out_valid(out_v_x[0]), .out_ready(o_rdy[0]), .sum(s0), .co(co_x[0])
`ifdef RS_SEG_ADD_OVF_EN
    , .ovf(ovf_x[0])
`endif
  );

  rs_seg_pipe_adder #(.WIDTH(100), .SEG_WIDTH(64)) u_dut1 (
    .C(C), .R(R_x[1]), .in_valid(in_v[1]), .in_ready(in_rdy_x[1]),
    .a(a_x[1][99:0]), .b(b_x[1][99:0]), .ci(ci_x[1]), .bi(bi_x[1]),
    .out_valid(out_v_x[1]), .out_ready(o_rdy[1]), .sum(s1), .co(co_x[1])
`ifdef RS_SEG_ADD_OVF_EN
    , .ovf(ovf_x[1])
`endif
  );

  rs_seg_pipe_adder #(.WIDTH(48), .SEG_WIDTH(64)) u_dut2 (
    .C(C), .R(R_x[2]), .in_valid(in_v[2]), .in_ready(in_rdy_x[2]),
    .a(a_x[2][47:0]), .b(b_x[2][47:0]), .ci(ci_x[2]), .bi(bi_x[2]),
    .out_valid(out_v_x[2]), .out_ready(o_rdy[2]), .sum(s2), .co(co_x[2])
`ifdef RS_SEG_ADD_OVF_EN
    , .ovf(ovf_x[2])
`endif
  );

  int n_chk, n_err;

  typedef struct {
    string        name;
    logic [127:0] a, b;
    logic         ci, bi;
    logic [127:0] exp_sum;
    logic         exp_co, exp_ovf;
  } vec_t;

  vec_t vecs [7];

  function automatic int wd(input int i);
    case (i)
      0:       return 128;
      1:       return 100;
      default: return 48;
    endcase
  endfunction

  function automatic int nsg(input int i);
    return (wd(i) + 63) / 64;
  endfunction

  function automatic logic [127:0] msk(input int w);
    logic [128:0] m;
    m = (129'd1 << w) - 129'd1;
    return m[127:0];
  endfunction

  function automatic logic [127:0] rnd(input int w);
    logic [127:0] v;
    case ($urandom_range(0, 5))
      0:       v = {128{1'b1}};
      1:       v = '0;
      2:       v = {64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v & msk(w);
  endfunction

  // Reference: plain (w+1)-bit arithmetic. Overflow is taken from operand and
  // result signs.
  task automatic ref_add(input int w, input logic [127:0] av, bv, input logic civ, biv,
                         output logic [127:0] s, output logic c, output logic ov);
    logic [128:0] full;
    logic [127:0] bx, am;
    am   = av & msk(w);
    bx   = (biv ? ~bv : bv) & msk(w);
    full = {1'b0, am} + {1'b0, bx} + {128'b0, civ};
    s    = full[127:0] & msk(w);
    c    = full[w];
    ov   = (am[w-1] == bx[w-1]) && (s[w-1] != am[w-1]);
  endtask

  task automatic check(input string nm, input logic [128:0] act, input logic [128:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Send one beat into an empty pipe with out_ready=1. Then check the latency and
  // the result. Called at posedge+1.
  task automatic single(input int i, input logic [127:0] av, bv, input logic civ, biv,
                        input logic [127:0] es, input logic ec, input logic eo,
                        input string nm);
    int lat;
    o_rdy[i] = 1'b1;
    in_v[i]  = 1'b1;
    a_x[i]   = av;
    b_x[i]   = bv;
    ci_x[i]  = civ;
    bi_x[i]  = biv;
    @(posedge C); #1;
    in_v[i] = 1'b0;
    lat = 1;
    while (!out_v_x[i] && lat < 20) begin
      @(posedge C); #1;
      lat++;
    end
    check({nm, " latency"}, lat, nsg(i));
    check({nm, " sum"}, sum_x[i], es);
    check({nm, " co"}, co_x[i], ec);
`ifdef RS_SEG_ADD_OVF_EN
    check({nm, " ovf"}, ovf_x[i], eo);
`else
    if (eo === 1'bx) $display("note: ovf expectation undefined for %s", nm);
`endif
    @(posedge C); #1;
  endtask

  // Random stream. Cycle by cycle, valid and ready are coin flips. Transfers
  // are logged at negedge into an in-order scoreboard. A stalled output must
  // hold its value.
  task automatic stream(input int i, input int nbeats, input int vld_pct, input int rdy_pct);
    logic [127:0] qs[$];
    logic         qc[$];
    logic         qo[$];
    logic [127:0] es, ps;
    logic         ec, eo, pc, prev_stall;
    int           sent, got, cyc;
    sent = 0; got = 0; cyc = 0; prev_stall = 1'b0; ps = '0; pc = 1'b0;
    while ((sent < nbeats || qs.size() > 0) && cyc < 3000) begin
      in_v[i] = (sent < nbeats) && ($urandom_range(0, 99) < vld_pct);
      a_x[i]  = rnd(wd(i));
      b_x[i]  = rnd(wd(i));
      ci_x[i] = 1'($urandom_range(0, 1));
      bi_x[i] = 1'($urandom_range(0, 1));
      o_rdy[i] = ($urandom_range(0, 99) < rdy_pct);
      @(negedge C);
      if (prev_stall) begin
        check("stall valid held", out_v_x[i], 1'b1);
        check("stall sum held", sum_x[i], ps);
        check("stall co held", co_x[i], pc);
      end
      if (in_v[i] && in_rdy_x[i]) begin
        ref_add(wd(i), a_x[i], b_x[i], ci_x[i], bi_x[i], es, ec, eo);
        qs.push_back(es); qc.push_back(ec); qo.push_back(eo);
        sent++;
      end
      if (out_v_x[i] && o_rdy[i]) begin
        if (qs.size() == 0) begin
          check("spurious output beat", 1'b1, 1'b0);
        end else begin
          es = qs.pop_front(); ec = qc.pop_front(); eo = qo.pop_front();
          check("stream sum", sum_x[i], es);
          check("stream co", co_x[i], ec);
`ifdef RS_SEG_ADD_OVF_EN
          check("stream ovf", ovf_x[i], eo);
`endif
          got++;
        end
      end
      prev_stall = out_v_x[i] && !o_rdy[i];
      ps = sum_x[i];
      pc = co_x[i];
      @(posedge C); #1;
      cyc++;
    end
    check("stream beats delivered", got, nbeats);
    if (vld_pct == 100 && rdy_pct == 100) check("full-rate cycle count", cyc, nbeats + nsg(i));
    in_v[i]  = 1'b0;
    o_rdy[i] = 1'b1;
    repeat (3) @(posedge C);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] es;
    logic         ec, eo, seen;
    n_chk = 0; n_err = 0;
    R_x = '0; in_v = '0; o_rdy = '1; ci_x = '0; bi_x = '0;
    for (int i = 0; i < 3; i++) begin a_x[i] = '0; b_x[i] = '0; end

    vecs[0] = '{"carry across slice", 128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'd1, 1'b0, 1'b0,
                128'h0000_0000_0000_0001_0000_0000_0000_0000, 1'b0, 1'b0};
    vecs[1] = '{"ones plus ci", {128{1'b1}}, 128'd0, 1'b1, 1'b0, 128'd0, 1'b1, 1'b0};
    vecs[2] = '{"5 minus 7", 128'd5, 128'd7, 1'b1, 1'b1,
                128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[3] = '{"7 minus 5", 128'd7, 128'd5, 1'b1, 1'b1, 128'd2, 1'b1, 1'b0};
    vecs[4] = '{"max pos plus 1", {1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, {1'b1, 127'b0}, 1'b0, 1'b1};
    vecs[5] = '{"ones plus ones", {128{1'b1}}, {128{1'b1}}, 1'b1, 1'b0, {128{1'b1}}, 1'b1, 1'b0};
    vecs[6] = '{"min neg minus 1", {1'b1, 127'b0}, 128'd1, 1'b1, 1'b1, {1'b0, {127{1'b1}}}, 1'b1, 1'b1};

    #12;
    check("reset out_valid", out_v_x, 3'b000);
    check("reset sum", sum_x[0], 128'd0);
    check("reset co", co_x, 3'b000);
    @(posedge C); #1;
    R_x = '1;
    #1;
    check("in_ready after reset", in_rdy_x, 3'b111);

    for (int t = 0; t < 7; t++)
      single(0, vecs[t].a, vecs[t].b, vecs[t].ci, vecs[t].bi,
             vecs[t].exp_sum, vecs[t].exp_co, vecs[t].exp_ovf, vecs[t].name);

    // Two beats in flight, then an asynchronous reset in the middle of the cycle.
    in_v[0] = 1'b1; a_x[0] = 128'd10; b_x[0] = 128'd20; ci_x[0] = 1'b0; bi_x[0] = 1'b0;
    @(posedge C); #1;
    a_x[0] = 128'd30; b_x[0] = 128'd40;
    @(posedge C); #1;
    in_v[0] = 1'b0;
    check("pre-reset out_valid", out_v_x[0], 1'b1);
    check("pre-reset sum", sum_x[0], 128'd30);
    #2;
    R_x[0] = 1'b0;
    #1;
    check("mid-reset out_valid", out_v_x[0], 1'b0);
    check("mid-reset sum", sum_x[0], 128'd0);
    check("mid-reset co", co_x[0], 1'b0);
    @(posedge C); #1;
    R_x[0] = 1'b1;
    seen = 1'b0;
    repeat (3) begin
      @(posedge C); #1;
      seen = seen | out_v_x[0];
    end
    check("no beat survives reset", seen, 1'b0);
    single(0, 128'd3, 128'd4, 1'b0, 1'b0, 128'd7, 1'b0, 1'b0, "post-reset 3+4");

    for (int i = 0; i < 3; i++) begin
      logic [127:0] ra, rb;
      ra = rnd(wd(i));
      rb = rnd(wd(i));
      ref_add(wd(i), ra, rb, 1'b1, 1'b0, es, ec, eo);
      single(i, ra, rb, 1'b1, 1'b0, es, ec, eo, "random single");
      stream(i, 100, 75, 50);
      stream(i, 30, 100, 100);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
